// File: rtl/tpiu_sync_lock_ctrl.sv
// Frame-lock controller for the 32-bit TPIU trace input: finds 16-byte frame
// alignment from full syncs, strips filler words and forwards aligned frame words.
module tpiu_sync_lock_ctrl #(
  parameter int unsigned LOCK_SYNCS   = 2,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CTRL_ENABLE,
  input  logic [31:0] IN_DATA,
  input  logic        IN_VALID,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  output logic        OUT_FIRST,
  output logic        OUT_LAST,
  output logic        OUT_ABORT,
  output logic        LOCKED,
  output logic [1:0]  LOCK_STATE,
  output logic [7:0]  RESYNC_COUNT
);

  localparam logic [31:0] FULL_WORD = 32'h7FFF_FFFF;
  localparam logic [31:0] HALF_WORD = 32'h7FFF_7FFF;
  localparam logic [4:0]  LOCK_NEED = 5'(LOCK_SYNCS);
  localparam logic [15:0] TMO_LIMIT = 16'(SYNC_TIMEOUT);

  // EXPIRE is the one cycle after the timing-out word: still reported as locked,
  // then drops to HUNT with the abort/resync bookkeeping.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10,
    ST_EXPIRE = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  word_idx, idx_nxt;
  logic [3:0]  sync_cnt, sync_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic        resync_inc;

  logic        is_full, is_data;
  logic        valid_nxt, first_nxt, last_nxt, abort_nxt;
  logic [1:0]  lock_state_nxt;

  assign is_full = IN_VALID && (IN_DATA == FULL_WORD);
  assign is_data = IN_VALID && (IN_DATA != FULL_WORD) && (IN_DATA != HALF_WORD);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= ST_HUNT;
      word_idx     <= 2'd0;
      sync_cnt     <= 4'd0;
      tmo_cnt      <= 16'd0;
      RESYNC_COUNT <= 8'd0;
    end else begin
      state    <= state_nxt;
      word_idx <= idx_nxt;
      sync_cnt <= sync_nxt;
      tmo_cnt  <= tmo_nxt;
      if (resync_inc && RESYNC_COUNT != 8'hFF)
        RESYNC_COUNT <= RESYNC_COUNT + 8'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = word_idx;
    sync_nxt   = sync_cnt;
    tmo_nxt    = tmo_cnt;
    resync_inc = 1'b0;
    if (!CTRL_ENABLE) begin
      state_nxt  = ST_HUNT;
      idx_nxt    = 2'd0;
      sync_nxt   = 4'd0;
      tmo_nxt    = 16'd0;
      resync_inc = (state == ST_LOCKED) || (state == ST_EXPIRE);
    end else begin
      case (state)
        ST_HUNT: begin
          if (is_full) begin
            idx_nxt   = 2'd0;
            sync_nxt  = 4'd1;
            tmo_nxt   = 16'd0;
            state_nxt = (LOCK_NEED <= 5'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (is_data) begin
            idx_nxt = word_idx + 2'd1;
          end else if (is_full) begin
            if (word_idx == 2'd0) begin
              sync_nxt = sync_cnt + 4'd1;
              if (({1'b0, sync_cnt} + 5'd1) >= LOCK_NEED) begin
                state_nxt = ST_LOCKED;
                tmo_nxt   = 16'd0;
              end
            end else begin
              sync_nxt = 4'd1;
              idx_nxt  = 2'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (is_data) begin
            idx_nxt = word_idx + 2'd1;
            tmo_nxt = tmo_cnt + 16'd1;
            if (TMO_LIMIT != 16'd0 && (tmo_cnt + 16'd1) == TMO_LIMIT)
              state_nxt = ST_EXPIRE;
          end else if (is_full) begin
            if (word_idx == 2'd0) begin
              tmo_nxt = 16'd0;
            end else begin
              state_nxt  = ST_VERIFY;
              sync_nxt   = 4'd1;
              idx_nxt    = 2'd0;
              resync_inc = 1'b1;
            end
          end
        end
        default: begin
          state_nxt  = ST_HUNT;
          idx_nxt    = 2'd0;
          sync_nxt   = 4'd0;
          tmo_nxt    = 16'd0;
          resync_inc = 1'b1;
        end
      endcase
    end
  end

  // Abort is raised whenever a partially delivered frame is abandoned.
  always_comb begin
    valid_nxt = CTRL_ENABLE && (state == ST_LOCKED) && is_data;
    first_nxt = valid_nxt && (word_idx == 2'd0);
    last_nxt  = valid_nxt && (word_idx == 2'd3);
    abort_nxt = 1'b0;
    if (word_idx != 2'd0) begin
      if (!CTRL_ENABLE)
        abort_nxt = (state == ST_LOCKED) || (state == ST_EXPIRE);
      else if (state == ST_EXPIRE)
        abort_nxt = 1'b1;
      else if (state == ST_LOCKED)
        abort_nxt = is_full;
    end
    lock_state_nxt = (state_nxt == ST_EXPIRE) ? 2'b10 : state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      OUT_DATA   <= 32'd0;
      OUT_VALID  <= 1'b0;
      OUT_FIRST  <= 1'b0;
      OUT_LAST   <= 1'b0;
      OUT_ABORT  <= 1'b0;
      LOCKED     <= 1'b0;
      LOCK_STATE <= 2'b00;
    end else begin
      if (valid_nxt)
        OUT_DATA <= IN_DATA;
      OUT_VALID  <= valid_nxt;
      OUT_FIRST  <= first_nxt;
      OUT_LAST   <= last_nxt;
      OUT_ABORT  <= abort_nxt;
      LOCKED     <= (lock_state_nxt == 2'b10);
      LOCK_STATE <= lock_state_nxt;
    end
  end

endmodule

// File: doc/tpiu_sync_lock_ctrl.md
# tpiu_sync_lock_ctrl

Frame-lock controller for the 32-bit TPIU trace input. It watches the raw word stream for full synchronisation packets, establishes and supervises 4-word (16-byte) frame alignment through a HUNT/VERIFY/LOCKED state machine, and strips sync and half-sync filler words. Aligned frame words go to the downstream frame decoder with first/last/abort markers, and lock status goes to the control/status register block.

## Interface
Parameters:
- LOCK_SYNCS, 2: consecutive frame-aligned full syncs required to enter LOCKED (legal range 1..15).
- SYNC_TIMEOUT, 1024: forwarded data words allowed in LOCKED without a full sync before lock is dropped; 0 disables the timeout; 16-bit range.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- CTRL_ENABLE  in  1  controller enable; low forces HUNT and idle outputs
- IN_DATA  in  32  raw TPIU word
- IN_VALID  in  1  IN_DATA qualifier
- OUT_DATA  out  32  aligned frame word
- OUT_VALID  out  1  OUT_DATA qualifier
- OUT_FIRST  out  1  word 0 of a frame (valid with OUT_VALID)
- OUT_LAST  out  1  word 3 of a frame (valid with OUT_VALID)
- OUT_ABORT  out  1  one-cycle pulse: current partial frame is discarded
- LOCKED  out  1  state == LOCKED
- LOCK_STATE  out  2  00 HUNT, 01 VERIFY, 10 LOCKED
- RESYNC_COUNT  out  8  saturating count of LOCKED exits; cleared only by reset

## Operation
- Word classes, decoded only when IN_VALID=1:
  - FULL = 32'h7FFFFFFF.
  - HALF = 32'h7FFF7FFF.
  - DATA = any other value.
- HALF words are discarded in every state. They do not advance the word index, timeout counter or sync count.
- Internal state:
  - word_idx: 2 bits, mod 4, advanced by DATA words.
  - sync_cnt: 4 bits.
  - tmo_cnt: 16 bits.
- HUNT:
  - DATA is discarded.
  - FULL: go to VERIFY, sync_cnt=1, word_idx=0.
  - If LOCK_SYNCS==1, FULL goes directly to LOCKED.
- VERIFY:
  - DATA: word_idx++, no output.
  - FULL with word_idx==0: sync_cnt++. If the new sync_cnt==LOCK_SYNCS, go to LOCKED with tmo_cnt=0.
  - FULL with word_idx!=0 (misaligned): stay in VERIFY, sync_cnt=1, word_idx=0.
- LOCKED:
  - DATA is forwarded with OUT_FIRST=(word_idx==0) and OUT_LAST=(word_idx==3), then word_idx++ and tmo_cnt++.
  - FULL with word_idx==0: tmo_cnt=0, nothing forwarded.
  - FULL with word_idx!=0: go to VERIFY, sync_cnt=1, word_idx=0, OUT_ABORT pulse, RESYNC_COUNT++.
  - Timeout: a forwarded DATA word that makes tmo_cnt reach SYNC_TIMEOUT is still forwarded. On the next cycle the state is HUNT and RESYNC_COUNT++. OUT_ABORT pulses only if that word was not word 3; it pulses on the cycle after that word's output.
- CTRL_ENABLE low:
  - State goes to HUNT and all counters except RESYNC_COUNT clear.
  - OUT_VALID=0. OUT_ABORT pulses once if LOCKED with word_idx!=0.
  - Leaving LOCKED this way increments RESYNC_COUNT.
  - Input words in that cycle are ignored.
- RESYNC_COUNT saturates at 255.
- IN_VALID=0 is a bubble: no state change, OUT_VALID=0.

## Timing
- All outputs are registered. Input-to-output latency is 1 cycle: the word sampled at edge N appears at edge N+1.
- LOCK_STATE, LOCKED and the OUT_ABORT caused by a misaligned sync update on the same edge as the offending word's output slot.
- Reset values: OUT_DATA=0, OUT_VALID=0, OUT_FIRST=0, OUT_LAST=0, OUT_ABORT=0, LOCKED=0, LOCK_STATE=00, RESYNC_COUNT=0, all internal counters 0.
- Reset mid-frame: all outputs return to reset values on the next edge, and no OUT_ABORT is issued.
- OUT_FIRST, OUT_LAST and OUT_ABORT are 0 whenever OUT_VALID=0, except the OUT_ABORT pulse itself, which is always issued with OUT_VALID=0.
- No backpressure: the downstream block must accept one word per cycle.

## Test plan
- Lock acquisition: with LOCK_SYNCS=2, send FULL, D0..D3, FULL, D4..D7 -> LOCKED rises 1 cycle after the 2nd FULL; D4..D7 are output with FIRST on D4 and LAST on D7; D0..D3 are never output.
- Filler transparency: while LOCKED, send D0, HALF, HALF, D1, D2, IN_VALID=0, D3 -> exactly 4 outputs, FIRST on D0, LAST on D3, LOCK_STATE stays 10.
- Misalignment: while LOCKED, send D0, D1, FULL -> D0 and D1 are output, then OUT_ABORT=1 with LOCK_STATE=01 and RESYNC_COUNT increments by 1.
- Timeout: with SYNC_TIMEOUT=6, while LOCKED send 6 DATA words and no FULL -> 6 outputs, then LOCK_STATE=00 and OUT_ABORT=1 (word 6 is frame word 1).
- Enable and reset: drop CTRL_ENABLE mid-frame -> single OUT_ABORT, LOCK_STATE=00, OUT_VALID=0 while low. Assert ARESETN=0 mid-frame -> all outputs 0 and RESYNC_COUNT=0.
- Saturation and direct lock: with LOCK_SYNCS=1, run 300 lock/misalign cycles -> RESYNC_COUNT holds at 255, and each FULL in HUNT gives LOCKED after 1 cycle.
